frame_parser: RTL and testbench

//  Receive-side counterpart of the frame former: accepts 64-bit AXIS Ethernet frames, parses the 18-byte header
//  (dst MAC 6, src MAC 6, link type 2, sync word 2, packet size 2), filters on dst/type/sync and strips the header.

---
 rtl/frame_parser.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_frame_parser.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_parser.sv
// frame_parser: receive-side header stripper for 64-bit AXIS Ethernet-style frames.
// Parses the 18-byte header (dst 6, src 6, type 2, sync 2, size 2), filters on dst/type/sync,
// and forwards the payload realigned to lane 0 through a single output register stage.
// Non-matching, runt and empty-payload frames are consumed and counted as drops.
module frame_parser #(
    parameter int unsigned DATA_WIDTH      = 64,  // only 64 is supported
    parameter bit          ALLOW_BROADCAST = 1'b1
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [DATA_WIDTH-1:0]     S_AXIS_tdata,
    input  logic [DATA_WIDTH/8-1:0]   S_AXIS_tkeep,
    input  logic                      S_AXIS_tvalid,
    input  logic                      S_AXIS_tlast,
    output logic                      S_AXIS_tready,
    output logic [DATA_WIDTH-1:0]     M_AXIS_tdata,
    output logic [DATA_WIDTH/8-1:0]   M_AXIS_tkeep,
    output logic                      M_AXIS_tvalid,
    output logic                      M_AXIS_tlast,
    output logic                      M_AXIS_tuser,
    input  logic                      M_AXIS_tready,
    input  logic [47:0]               Local_Address,
    input  logic [15:0]               Link_Type,
    input  logic [15:0]               SyncWord,
    output logic [47:0]               Rx_Source_Address,
    output logic [13:0]               Rx_Packet_Size,
    output logic                      Frame_Good,
    output logic                      Frame_Dropped,
    output logic                      Length_Error,
    output logic [15:0]               Drop_Count
);

    typedef enum logic [2:0] {
        StHdr0,
        StHdr1,
        StHdr2,
        StPayload,
        StFlush,
        StDrop
    } state_t;

    // Number of valid lanes in a beat; tkeep is contiguous from lane 0.
    function automatic logic [3:0] popcount8(input logic [7:0] k);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, k[i]};
        end
        return c;
    endfunction

    // Keep mask with the n lowest lanes set.
    function automatic logic [7:0] low_mask(input logic [3:0] n);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m[i] = (i < int'(n));
        end
        return m;
    endfunction

    state_t                  state_q, state_d;
    logic [47:0]             dst_q, dst_d;
    logic [47:0]             src_q, src_d;
    logic [15:0]             type_q, type_d;
    logic [15:0]             sync_q, sync_d;
    logic [13:0]             size_q, size_d;
    logic [DATA_WIDTH-1:0]   prev_q, prev_d;
    logic [3:0]              rem_q, rem_d;
    logic [15:0]             cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [7:0]              out_keep_q, out_keep_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic                    out_user_q, out_user_d;

    logic [47:0]             rx_src_q, rx_src_d;
    logic [13:0]             rx_size_q, rx_size_d;
    logic [15:0]             drop_cnt_q, drop_cnt_d;

    logic                    s_ready;
    logic                    s_fire;
    logic                    m_fire;
    logic                    out_free;
    logic                    drop_now;
    logic                    hdr_match;
    logic [3:0]              beat_bytes;
    logic [15:0]             cnt_sum;

    assign s_fire     = S_AXIS_tvalid && s_ready;
    assign m_fire     = out_valid_q && M_AXIS_tready;
    assign out_free   = !out_valid_q || M_AXIS_tready;
    assign beat_bytes = popcount8(S_AXIS_tkeep);
    assign cnt_sum    = cnt_q + 16'(beat_bytes);
    assign hdr_match  = ((dst_q == Local_Address) || (ALLOW_BROADCAST && (&dst_q)))
                        && (type_q == Link_Type) && (sync_q == SyncWord);

    // Next-state, header capture, realignment and output-register load.
    always_comb begin
        state_d     = state_q;
        dst_d       = dst_q;
        src_d       = src_q;
        type_d      = type_q;
        sync_d      = sync_q;
        size_d      = size_q;
        prev_d      = prev_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_valid_d = out_valid_q && !M_AXIS_tready;
        out_last_d  = out_last_q;
        out_user_d  = out_user_q;
        rx_src_d    = rx_src_q;
        rx_size_d   = rx_size_q;
        s_ready     = 1'b0;
        drop_now    = 1'b0;

        case (state_q)
            StHdr0: begin
                s_ready = 1'b1;
                if (s_fire) begin
                    dst_d = {S_AXIS_tdata[7:0], S_AXIS_tdata[15:8], S_AXIS_tdata[23:16],
                             S_AXIS_tdata[31:24], S_AXIS_tdata[39:32], S_AXIS_tdata[47:40]};
                    src_d[47:32] = {S_AXIS_tdata[55:48], S_AXIS_tdata[63:56]};
                    if (S_AXIS_tlast) begin
                        drop_now = 1'b1;
                    end else begin
                        state_d = StHdr1;
                    end
                end
            end
            StHdr1: begin
                s_ready = 1'b1;
                if (s_fire) begin
                    src_d[31:0] = {S_AXIS_tdata[7:0], S_AXIS_tdata[15:8],
                                   S_AXIS_tdata[23:16], S_AXIS_tdata[31:24]};
                    type_d = {S_AXIS_tdata[39:32], S_AXIS_tdata[47:40]};
                    sync_d = {S_AXIS_tdata[55:48], S_AXIS_tdata[63:56]};
                    if (S_AXIS_tlast) begin
                        drop_now = 1'b1;
                        state_d  = StHdr0;
                    end else begin
                        state_d = StHdr2;
                    end
                end
            end
            StHdr2: begin
                s_ready = 1'b1;
                if (s_fire) begin
                    prev_d = S_AXIS_tdata;
                    // Top two bits of the size field are not part of the length.
                    size_d = {S_AXIS_tdata[5:0], S_AXIS_tdata[15:8]};
                    if (!hdr_match) begin
                        drop_now = 1'b1;
                        state_d  = S_AXIS_tlast ? StHdr0 : StDrop;
                    end else begin
                        rx_src_d  = src_q;
                        rx_size_d = {S_AXIS_tdata[5:0], S_AXIS_tdata[15:8]};
                        if (!S_AXIS_tlast) begin
                            cnt_d   = 16'd6;
                            state_d = StPayload;
                        end else if (beat_bytes <= 4'd2) begin
                            drop_now = 1'b1;
                            state_d  = StHdr0;
                        end else begin
                            cnt_d   = 16'(beat_bytes - 4'd2);
                            rem_d   = beat_bytes - 4'd2;
                            state_d = StFlush;
                        end
                    end
                end
            end
            StPayload: begin
                s_ready = out_free;
                if (s_fire) begin
                    prev_d      = S_AXIS_tdata;
                    cnt_d       = cnt_sum;
                    out_data_d  = {S_AXIS_tdata[15:0], prev_q[63:16]};
                    out_valid_d = 1'b1;
                    out_keep_d  = 8'hFF;
                    out_last_d  = 1'b0;
                    out_user_d  = 1'b0;
                    if (S_AXIS_tlast) begin
                        if (beat_bytes <= 4'd2) begin
                            out_keep_d = low_mask(4'd6 + beat_bytes);
                            out_last_d = 1'b1;
                            out_user_d = (cnt_sum != {2'b00, size_q});
                            state_d    = StHdr0;
                        end else begin
                            rem_d   = beat_bytes - 4'd2;
                            state_d = StFlush;
                        end
                    end
                end
            end
            StFlush: begin
                // Emit the tail bytes still held in prev once the register frees up.
                if (out_free) begin
                    out_data_d  = {16'h0000, prev_q[63:16]};
                    out_keep_d  = low_mask(rem_q);
                    out_last_d  = 1'b1;
                    out_user_d  = (cnt_q != {2'b00, size_q});
                    out_valid_d = 1'b1;
                    state_d     = StHdr0;
                end
            end
            StDrop: begin
                s_ready = 1'b1;
                if (s_fire && S_AXIS_tlast) begin
                    state_d = StHdr0;
                end
            end
            default: begin
                state_d = StHdr0;
            end
        endcase

        drop_cnt_d = drop_cnt_q;
        if (drop_now && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= StHdr0;
            dst_q       <= '0;
            src_q       <= '0;
            type_q      <= '0;
            sync_q      <= '0;
            size_q      <= '0;
            prev_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
            rx_src_q    <= '0;
            rx_size_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            type_q      <= type_d;
            sync_q      <= sync_d;
            size_q      <= size_d;
            prev_q      <= prev_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_user_q  <= out_user_d;
            rx_src_q    <= rx_src_d;
            rx_size_q   <= rx_size_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign S_AXIS_tready     = s_ready;
    assign M_AXIS_tdata      = out_data_q;
    assign M_AXIS_tkeep      = out_keep_q;
    assign M_AXIS_tvalid     = out_valid_q;
    assign M_AXIS_tlast      = out_last_q;
    assign M_AXIS_tuser      = out_user_q;
    assign Rx_Source_Address = rx_src_q;
    assign Rx_Packet_Size    = rx_size_q;
    assign Drop_Count        = drop_cnt_q;
    // Status pulses coincide with the handshake that decides them.
    assign Frame_Good        = m_fire && out_last_q && !ARESET;
    assign Length_Error      = m_fire && out_last_q && out_user_q && !ARESET;
    assign Frame_Dropped     = drop_now && !ARESET;

endmodule

// File: tb/tb_frame_parser.sv
// Testbench for frame_parser: table of directed frames, backpressure and reset sequences,
// then random frames checked against a byte-level reference model.
module tb_frame_parser;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    typedef struct {
        int          dst_kind;   // 0 local, 1 broadcast, 2 other
        bit          type_ok;
        bit          sync_ok;
        int          plen;
        int          total;      // 0: full frame, else truncate to this many bytes
        logic [15:0] size;
        int          exp_good;
        int          exp_drop;
        int          exp_beats;
        logic [7:0]  exp_keep;
        bit          exp_user;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tuser;
    logic        m_tready;
    logic [47:0] local_addr;
    logic [15:0] link_type;
    logic [15:0] sync_word;
    logic [47:0] rx_src;
    logic [13:0] rx_size;
    logic        frame_good;
    logic        frame_dropped;
    logic        length_error;
    logic [15:0] drop_count;

    int          tests;
    int          errors;
    int          good_seen, drop_seen, lerr_seen, beats_seen;
    logic [7:0]  last_keep_seen;
    logic        last_user_seen;
    beat_t       exp_q[$];
    int          exp_drops, exp_goods, exp_lerrs, exp_drop_count;
    logic [47:0] exp_rx_src;
    logic [13:0] exp_rx_size;
    bit          rand_ready;
    bit          rand_gap;
    vec_t        vecs[13];

    always #5 clk = ~clk;

    frame_parser #(
        .DATA_WIDTH      (64),
        .ALLOW_BROADCAST (1'b1)
    ) dut (
        .ACLK              (clk),
        .ARESET            (rst),
        .S_AXIS_tdata      (s_tdata),
        .S_AXIS_tkeep      (s_tkeep),
        .S_AXIS_tvalid     (s_tvalid),
        .S_AXIS_tlast      (s_tlast),
        .S_AXIS_tready     (s_tready),
        .M_AXIS_tdata      (m_tdata),
        .M_AXIS_tkeep      (m_tkeep),
        .M_AXIS_tvalid     (m_tvalid),
        .M_AXIS_tlast      (m_tlast),
        .M_AXIS_tuser      (m_tuser),
        .M_AXIS_tready     (m_tready),
        .Local_Address     (local_addr),
        .Link_Type         (link_type),
        .SyncWord          (sync_word),
        .Rx_Source_Address (rx_src),
        .Rx_Packet_Size    (rx_size),
        .Frame_Good        (frame_good),
        .Frame_Dropped     (frame_dropped),
        .Length_Error      (length_error),
        .Drop_Count        (drop_count)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic timeout_abort(input string name);
        tests++;
        errors++;
        $display("FAIL %s: timed out waiting for handshake", name);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    endtask

    // Build a frame as a byte list from header fields and a random payload.
    task automatic build_frame(input int dst_kind, input bit type_ok, input bit sync_ok,
                               input int plen, input int total, input logic [15:0] size,
                               output byte_q_t b);
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] typ;
        logic [15:0] syn;
        b = {};
        src = 48'({$urandom(), $urandom()});
        dst = (dst_kind == 0) ? local_addr :
              (dst_kind == 1) ? 48'hFFFF_FFFF_FFFF : (local_addr ^ 48'h0000_0000_0100);
        typ = type_ok ? link_type : (link_type ^ 16'h0100);
        syn = sync_ok ? sync_word : (sync_word ^ 16'h0001);
        for (int i = 0; i < 6; i++) b.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) b.push_back(src[47-8*i -: 8]);
        b.push_back(typ[15:8]);
        b.push_back(typ[7:0]);
        b.push_back(syn[15:8]);
        b.push_back(syn[7:0]);
        b.push_back(size[15:8]);
        b.push_back(size[7:0]);
        for (int i = 0; i < plen; i++) b.push_back(8'($urandom_range(0, 255)));
        if (total != 0) begin
            while (b.size() > total) void'(b.pop_back());
        end
    endtask

    // Reference model: decide the fate of a whole frame from its bytes.
    task automatic model_frame(input byte_q_t b);
        int          len;
        int          p;
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] typ;
        logic [15:0] syn;
        logic [15:0] sz;
        beat_t       e;
        len = b.size();
        if (len <= 16) begin
            exp_drops++;
            exp_drop_count++;
            return;
        end
        dst = {b[0], b[1], b[2], b[3], b[4], b[5]};
        src = {b[6], b[7], b[8], b[9], b[10], b[11]};
        typ = {b[12], b[13]};
        syn = {b[14], b[15]};
        sz  = {b[16], b[17]};
        if (!((dst == local_addr || dst == 48'hFFFF_FFFF_FFFF) && typ == link_type
              && syn == sync_word)) begin
            exp_drops++;
            exp_drop_count++;
            return;
        end
        exp_rx_src  = src;
        exp_rx_size = sz[13:0];
        p = len - 18;
        if (p <= 0) begin
            exp_drops++;
            exp_drop_count++;
            return;
        end
        exp_goods++;
        if (p != int'(sz[13:0])) exp_lerrs++;
        for (int off = 0; off < p; off += 8) begin
            e.data = '0;
            e.keep = '0;
            for (int i = 0; i < 8; i++) begin
                if (off + i < p) begin
                    e.data[8*i +: 8] = b[18 + off + i];
                    e.keep[i] = 1'b1;
                end
            end
            e.last = (off + 8 >= p);
            e.user = e.last && (p != int'(sz[13:0]));
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int guard;
        guard = 0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            guard++;
            if (guard > 2000) timeout_abort("s_axis_beat");
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic drive_frame(input byte_q_t b, input int max_beats);
        int          nb;
        logic [63:0] d;
        logic [7:0]  k;
        nb = (b.size() + 7) / 8;
        for (int j = 0; j < nb && j < max_beats; j++) begin
            d = '0;
            k = '0;
            for (int i = 0; i < 8; i++) begin
                if (8*j + i < b.size()) begin
                    d[8*i +: 8] = b[8*j + i];
                    k[i] = 1'b1;
                end
            end
            if (rand_gap) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            drive_beat(d, k, (j == nb - 1));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 || m_tvalid) begin
            @(negedge clk);
            n++;
            if (n > 500) timeout_abort("wait_idle");
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_beat();
        beat_t e;
        bit    ok;
        tests++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got data=%h keep=%h last=%b, required no beat",
                     m_tdata, m_tkeep, m_tlast);
        end else begin
            e  = exp_q.pop_front();
            ok = (m_tkeep == e.keep) && (m_tlast == e.last) && (m_tuser == e.user);
            for (int i = 0; i < 8; i++) begin
                if (e.keep[i] && (m_tdata[8*i +: 8] !== e.data[8*i +: 8])) ok = 1'b0;
            end
            if (!ok) begin
                errors++;
                $display("FAIL m_axis_beat: got data=%h keep=%h last=%b user=%b, required data=%h keep=%h last=%b user=%b",
                         m_tdata, m_tkeep, m_tlast, m_tuser, e.data, e.keep, e.last, e.user);
            end
        end
        beats_seen++;
        last_keep_seen = m_tkeep;
        last_user_seen = m_tuser;
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_tvalid && m_tready) check_beat();
                if (frame_good) good_seen++;
                if (length_error) lerr_seen++;
                if (frame_dropped) drop_seen++;
            end
            @(posedge clk);
            #1;
            if (rand_ready) m_tready = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        byte_q_t     fr;
        int          g0, d0, b0, r, plen, tot;
        logic [15:0] sz;

        tests = 0; errors = 0;
        good_seen = 0; drop_seen = 0; lerr_seen = 0; beats_seen = 0;
        exp_drops = 0; exp_goods = 0; exp_lerrs = 0; exp_drop_count = 0;
        exp_rx_src = '0; exp_rx_size = '0;
        last_keep_seen = '0; last_user_seen = 1'b0;
        rand_ready = 1'b0; rand_gap = 1'b0;
        rst = 1'b1;
        s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        m_tready = 1'b1;
        local_addr = 48'h02_11_22_33_44_55;
        link_type  = 16'h88B5;
        sync_word  = 16'hA55A;

        //          dst typ syn plen tot size        good drp bts keep  user
        vecs[0]  = '{0, 1, 1, 16, 0,  16'd16,     1, 0, 2, 8'hFF, 1'b0};
        vecs[1]  = '{0, 1, 1, 4,  0,  16'd5,      1, 0, 1, 8'h0F, 1'b1};
        vecs[2]  = '{0, 0, 1, 30, 0,  16'd30,     0, 1, 0, 8'h00, 1'b0};
        vecs[3]  = '{1, 1, 1, 8,  0,  16'd8,      1, 0, 1, 8'hFF, 1'b0};
        vecs[4]  = '{0, 1, 1, 0,  10, 16'd0,      0, 1, 0, 8'h00, 1'b0};
        vecs[5]  = '{0, 1, 1, 13, 0,  16'd13,     1, 0, 2, 8'h1F, 1'b0};
        vecs[6]  = '{0, 1, 0, 5,  0,  16'd5,      0, 1, 0, 8'h00, 1'b0};
        vecs[7]  = '{0, 1, 1, 0,  0,  16'd0,      0, 1, 0, 8'h00, 1'b0};
        vecs[8]  = '{0, 1, 1, 6,  0,  16'd6,      1, 0, 1, 8'h3F, 1'b0};
        vecs[9]  = '{2, 1, 1, 8,  0,  16'd8,      0, 1, 0, 8'h00, 1'b0};
        vecs[10] = '{0, 1, 1, 10, 0,  16'h400A,   1, 0, 2, 8'h03, 1'b0};
        vecs[11] = '{0, 1, 1, 9,  0,  16'd9,      1, 0, 2, 8'h01, 1'b0};
        vecs[12] = '{0, 1, 1, 2,  0,  16'd3,      1, 0, 1, 8'h03, 1'b1};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_s_tready", 64'(s_tready), 64'd1);
        check("reset_m_tvalid", 64'(m_tvalid), 64'd0);
        check("reset_drop_count", 64'(drop_count), 64'd0);
        check("reset_rx_src", 64'(rx_src), 64'd0);
        check("reset_rx_size", 64'(rx_size), 64'd0);
        check("reset_pulses", 64'({frame_good, frame_dropped, length_error}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        fork
            monitor_loop();
        join_none

        // Directed table.
        rand_ready = 1'b1;
        for (int v = 0; v < 13; v++) begin
            g0 = good_seen; d0 = drop_seen; b0 = beats_seen;
            build_frame(vecs[v].dst_kind, vecs[v].type_ok, vecs[v].sync_ok, vecs[v].plen,
                        vecs[v].total, vecs[v].size, fr);
            model_frame(fr);
            drive_frame(fr, 1000);
            wait_idle();
            check($sformatf("vec%0d_good", v), 64'(good_seen - g0), 64'(vecs[v].exp_good));
            check($sformatf("vec%0d_drop", v), 64'(drop_seen - d0), 64'(vecs[v].exp_drop));
            check($sformatf("vec%0d_beats", v), 64'(beats_seen - b0), 64'(vecs[v].exp_beats));
            if (vecs[v].exp_beats > 0) begin
                check($sformatf("vec%0d_last_keep", v), 64'(last_keep_seen),
                      64'(vecs[v].exp_keep));
                check($sformatf("vec%0d_tuser", v), 64'(last_user_seen),
                      64'(vecs[v].exp_user));
            end
        end
        check("table_drop_count", 64'(drop_count), 64'(exp_drop_count));
        check("table_length_errors", 64'(lerr_seen), 64'(exp_lerrs));
        check("table_rx_src", 64'(rx_src), 64'(exp_rx_src));

        // Backpressure: 13-byte payload, sink stalled for 5 cycles during FLUSH.
        rand_ready = 1'b0;
        m_tready   = 1'b0;
        build_frame(0, 1, 1, 13, 0, 16'd13, fr);
        model_frame(fr);
        drive_frame(fr, 1000);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d_m_tvalid", c), 64'(m_tvalid), 64'd1);
            check($sformatf("stall%0d_m_tdata", c), m_tdata, exp_q[0].data);
            check($sformatf("stall%0d_s_tready", c), 64'(s_tready), 64'd0);
        end
        @(posedge clk);
        #1;
        m_tready   = 1'b1;
        rand_ready = 1'b1;
        wait_idle();

        // Reset in the middle of a payload, then a clean frame.
        rand_ready = 1'b0;
        m_tready   = 1'b0;
        build_frame(0, 1, 1, 40, 0, 16'd40, fr);
        drive_frame(fr, 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_drop_count = 0;
        exp_rx_src     = '0;
        exp_rx_size    = '0;
        @(negedge clk);
        check("midreset_m_tvalid", 64'(m_tvalid), 64'd0);
        check("midreset_rx_src", 64'(rx_src), 64'd0);
        check("midreset_rx_size", 64'(rx_size), 64'd0);
        check("midreset_drop_count", 64'(drop_count), 64'd0);
        check("midreset_s_tready", 64'(s_tready), 64'd1);
        @(posedge clk);
        #1;
        m_tready   = 1'b1;
        rand_ready = 1'b1;
        g0 = good_seen;
        build_frame(0, 1, 1, 21, 0, 16'd21, fr);
        model_frame(fr);
        drive_frame(fr, 1000);
        wait_idle();
        check("postreset_good", 64'(good_seen - g0), 64'd1);
        check("postreset_rx_size", 64'(rx_size), 64'(exp_rx_size));

        // Random frames against the reference model.
        rand_gap = 1'b1;
        for (int f = 0; f < 60; f++) begin
            r    = $urandom_range(0, 9);
            plen = $urandom_range(0, 45);
            tot  = (r == 0) ? $urandom_range(1, 16) : 0;
            sz   = ($urandom_range(0, 1) == 1) ? 16'(plen) : 16'($urandom_range(0, 65535));
            build_frame((r == 1) ? 2 : (r == 4) ? 1 : 0, r != 2, r != 3, plen, tot, sz, fr);
            model_frame(fr);
            drive_frame(fr, 1000);
        end
        wait_idle();
        check("final_drop_pulses", 64'(drop_seen), 64'(exp_drops));
        check("final_good_pulses", 64'(good_seen), 64'(exp_goods));
        check("final_length_errors", 64'(lerr_seen), 64'(exp_lerrs));
        check("final_drop_count", 64'(drop_count), 64'(exp_drop_count));
        check("final_rx_src", 64'(rx_src), 64'(exp_rx_src));
        check("final_rx_size", 64'(rx_size), 64'(exp_rx_size));
        check("final_pending_beats", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
